// File: rtl/simpleio_ex.sv
// Memory-mapped simple I/O peripheral: LEDs, RGB channels, debounced switches/keys,
// latched key-press flags and a maskable interrupt. Optional LED blink via SIMPLEIO_BLINK_EN.
module simpleio_ex #(
  parameter int LED_W      = 8,
  parameter int NUM_RGB    = 2,
  parameter int SW_W       = 4,
  parameter int KEY_W      = 4,
  parameter int DEB_CYCLES = 16,
  parameter int BLINK_DIV  = 4194304
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           Address,
  input  logic [7:0]           DI,
  output logic [7:0]           DO,
  input  logic                 rw,
  input  logic                 cs,
  output logic [LED_W-1:0]     leds,
  output logic [3*NUM_RGB-1:0] rgb,
  input  logic [SW_W-1:0]      sw,
  input  logic [KEY_W-1:0]     key,
  output logic                 irq
);

  localparam int IN_W = SW_W + KEY_W;
  localparam int CW   = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  // Bus: a write is cs=1 & rw=0 at the clock edge; any other edge is a read of Address,
  // whose data appears on DO one clock later. There is no wait state or handshake.
  logic wr;
  assign wr = cs & ~rw;

  logic [IN_W-1:0]  in_raw;
  logic [IN_W-1:0]  sync1;
  logic [IN_W-1:0]  sync2;
  logic [IN_W-1:0]  db;
  logic [CW-1:0]    deb_cnt [IN_W];
  logic [IN_W-1:0]  deb_fire;
  logic [KEY_W-1:0] key_rise;

  logic [LED_W-1:0] led_reg;
  logic [KEY_W-1:0] edge_flags;
  logic [KEY_W-1:0] irq_en;
  logic [KEY_W-1:0] edge_clr;
  logic [2:0]       rgb_reg [NUM_RGB];
  logic [2:0]       rgb_rd  [4];
  logic [7:0]       rd_data;

  assign in_raw = {sw, key};

  // deb_fire marks the edge on which a bit's debounced value takes the synced value.
  always_comb begin
    deb_fire = '0;
    for (int i = 0; i < IN_W; i++) begin
      deb_fire[i] = (sync2[i] != db[i]) && (deb_cnt[i] == DEB_LAST);
    end
  end

  assign key_rise = deb_fire[KEY_W-1:0] & sync2[KEY_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < IN_W; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1 <= in_raw;
      sync2 <= sync1;
      for (int i = 0; i < IN_W; i++) begin
        if (sync2[i] == db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_fire[i]) begin
          db[i]      <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign edge_clr = (wr && (Address == 4'h2)) ? DI[KEY_W-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg    <= '0;
      edge_flags <= '0;
      irq_en     <= '0;
      irq        <= 1'b0;
      for (int n = 0; n < NUM_RGB; n++) begin
        rgb_reg[n] <= '0;
      end
    end else begin
      if (wr && (Address == 4'h0)) begin
        led_reg <= DI[LED_W-1:0];
      end
      if (wr && (Address == 4'h3)) begin
        irq_en <= DI[KEY_W-1:0];
      end
      for (int n = 0; n < NUM_RGB; n++) begin
        if (wr && (Address == 4'(4 + n))) begin
          rgb_reg[n] <= DI[2:0];
        end
      end
      // A new press on the same edge as its clear keeps the flag set.
      edge_flags <= (edge_flags & ~edge_clr) | key_rise;
      irq        <= |(edge_flags & irq_en);
    end
  end

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      rgb_rd[n] = '0;
    end
    for (int n = 0; n < NUM_RGB; n++) begin
      rgb_rd[n] = rgb_reg[n];
    end
  end

  for (genvar g = 0; g < NUM_RGB; g++) begin : g_rgb
    assign rgb[3*g+2:3*g] = rgb_reg[g];
  end

`ifdef SIMPLEIO_BLINK_EN
  localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_DIV - 1);

  logic [PW-1:0]    prescaler;
  logic             phase;
  logic [LED_W-1:0] blink_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler  <= '0;
      phase      <= 1'b0;
      blink_mask <= '0;
    end else begin
      if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        phase     <= ~phase;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      if (wr && (Address == 4'h8)) begin
        blink_mask <= DI[LED_W-1:0];
      end
    end
  end

  assign leds = led_reg ^ (blink_mask & {LED_W{phase}});
`else
  assign leds = led_reg;
`endif

  always_comb begin
    rd_data = '0;
    case (Address)
      4'h0: rd_data = 8'(led_reg);
      4'h1: rd_data = 8'(db);
      4'h2: rd_data = 8'(edge_flags);
      4'h3: rd_data = 8'(irq_en);
      4'h4, 4'h5, 4'h6, 4'h7: rd_data = {5'b0, rgb_rd[Address[1:0]]};
`ifdef SIMPLEIO_BLINK_EN
      4'h8: rd_data = 8'(blink_mask);
`endif
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DO <= '0;
    end else if (!wr) begin
      DO <= rd_data;
    end
  end

endmodule

// File: doc/simpleio_ex.md
Name: simpleio_ex

Overview:
- Parametrised successor to the board's simple I/O peripheral: memory-mapped LEDs, N RGB channels, switches and keys on the 8-bit CPU bus.
- Adds per-bit input synchronisation and debounce, latched key-press flags with write-1-to-clear, and a maskable interrupt.
- Sits on the CPU bus decoder, one chip-select, 16-byte window.

Parameters:
- LED_W, 8, LED output width (1..8).
- NUM_RGB, 2, RGB channel count (1..4), 3 bits each.
- SW_W, 4, switch input width; KEY_W, 4, key input width; SW_W+KEY_W <= 8.
- DEB_CYCLES, 16, clocks an input must differ from its debounced value before the debounced value updates (>= 2).
- BLINK_DIV, 4194304, clocks per blink phase toggle (optional feature only).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Address  in  4  register offset.
- DI  in  8  write data.
- DO  out  8  read data, registered.
- rw  in  1  1 = read, 0 = write.
- cs  in  1  chip select.
- leds  out  LED_W  LED drive.
- rgb  out  3*NUM_RGB  RGB drive, channel n at [3n+2:3n].
- sw  in  SW_W  raw switches, asynchronous.
- key  in  KEY_W  raw keys, asynchronous, active-high pressed.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset (rst_n=0, immediate): DO, leds, rgb, led_reg, edge, irq_en, blink_mask, debounce counters, sync flops, db = 0; irq = 0.
- Register map (Address):
  - 0x0 LEDS R/W: led_reg[LED_W-1:0]; upper bits read 0.
  - 0x1 INPUT R: {db_sw, db_key} right-justified, zero-padded; writes ignored.
  - 0x2 EDGE R/W1C: key press flags [KEY_W-1:0].
  - 0x3 IRQEN R/W: mask [KEY_W-1:0].
  - 0x4..0x7 RGB0..RGB3 R/W: DI[2:0]; channels >= NUM_RGB read 0, writes ignored.
  - 0x8 BLINK (optional feature only); all other offsets read 0, writes ignored.
- Write: cs=1 & rw=0 at clk edge; target updates that edge, visible on outputs next cycle.
- Read: when not a write, DO <= mux(Address) every edge, so DO is valid one clock after Address. Reads have no side effects. During a write, DO holds.
- Input path per bit: 2-flop synchroniser -> sync.
  - sync == db: counter cleared.
  - Otherwise the counter increments; when it reaches DEB_CYCLES-1, db <= sync and the counter clears.
  - Any glitch back to db before then clears the counter.
  - Latency raw->db: 2 + DEB_CYCLES clocks.
- Edge flag: db_key 0->1 sets edge[i]. Write 0x2 clears bits where DI=1. Set and clear in the same cycle: set wins.
- irq = |(edge & irq_en), registered, one clock after the flag sets.
- leds = led_reg (plus blink when enabled); rgb direct from registers.

Optional Feature:
- SIMPLEIO_BLINK_EN defined:
  - Prescaler counts 0..BLINK_DIV-1; phase toggles on wrap.
  - Register 0x8 R/W blink_mask[LED_W-1:0].
  - leds = led_reg ^ (blink_mask & {LED_W{phase}}).
  - Prescaler, phase and mask reset to 0.
- Undefined: no prescaler; 0x8 reads 0, writes ignored; leds = led_reg.

Test Plan:
- Reset: pulse rst_n low mid-run -> all outputs 0 immediately; read 0x0/0x2/0x3/0x4 -> DO=0x00.
- LED write 0xA5 to 0x0, then read 0x0 -> leds=0xA5 next cycle; DO=0xA5 one clock after the read address.
- Debounce (DEB_CYCLES=16): key[0] high 10 clocks -> db unchanged, no edge. Key[0] held high -> INPUT bit0=1 exactly 18 clocks after the change; edge=0x1.
- IRQ: IRQEN=0x1, key[0] press -> irq=1.
  - Write EDGE 0x1 -> irq=0.
  - W1C on the same cycle as a new rising edge on key[0] -> edge[0] stays 1.
- RGB with NUM_RGB=2: write 0x07 to 0x4 and 0x05 to 0x5 -> rgb=6'b101111. Write to 0x6 -> rgb unchanged, read 0x6 -> 0x00.
- Blink (SIMPLEIO_BLINK_EN, BLINK_DIV=4): led_reg=0x0F, mask=0x01 -> leds alternates 0x0F/0x0E every 4 clocks. Without the macro: read 0x8 -> 0x00.
